// File: rtl/vram_scan_arbiter.sv
// Shares the single-port playfield cell RAM between the VGA scan read path
// (owns the frame) and budgeted game-logic writes confined to vertical blanking.
module vram_scan_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned WR_BUDGET  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_stall,
  output logic              wr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] cell_data,
  output logic              cell_valid,
  output logic              frame_tick
);

  localparam int unsigned AW1 = ADDR_W + 1;
  localparam int unsigned BW  = $clog2(WR_BUDGET + 1);

  localparam logic [9:0]     H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]     V_ACT   = 10'(V_ACTIVE);
  localparam logic [AW1-1:0] N_CELLS = AW1'(GRID_W * GRID_H);
  localparam logic [BW-1:0]  BUDGET  = BW'(WR_BUDGET);

  typedef enum logic {
    DISP  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       budget_q, budget_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_stall_q, wr_stall_d;
  logic                wr_err_q, wr_err_d;
  logic                frame_tick_q, frame_tick_d;
  logic                rd_pipe_q, rd_pipe_d;
  logic                cell_valid_q, cell_valid_d;
  logic [DATA_W-1:0]   cell_data_q, cell_data_d;

  logic                vis;
  logic                vblank;
  logic                in_range;
  logic [ADDR_W-1:0]   scan_addr;

  assign vis      = (pos_x < H_ACT) && (pos_y < V_ACT);
  assign vblank   = (pos_y >= V_ACT);
  assign in_range = ({1'b0, wr_addr} < N_CELLS);
  // Row*width product is formed one bit wider than the RAM address, then truncated.
  assign scan_addr = ADDR_W'(AW1'(pos_y >> CELL_SHIFT) * AW1'(GRID_W)
                             + AW1'(pos_x >> CELL_SHIFT));

  always_comb begin
    state_d      = state_q;
    budget_d     = budget_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wr_ack_d     = 1'b0;
    wr_stall_d   = wr_stall_q;
    wr_err_d     = wr_err_q;
    frame_tick_d = 1'b0;
    // Read issued -> RAM samples next edge -> data captured the edge after.
    rd_pipe_d    = ram_en_q && !ram_we_q;
    cell_valid_d = rd_pipe_q;
    cell_data_d  = rd_pipe_q ? ram_rdata : cell_data_q;

    unique case (state_q)
      DISP: begin
        if (vblank) begin
          state_d      = BLANK;
          frame_tick_d = 1'b1;
          budget_d     = BUDGET;
          wr_stall_d   = 1'b0;
        end else if (vis) begin
          ram_en_d   = 1'b1;
          ram_addr_d = scan_addr;
        end
      end
      BLANK: begin
        if (!vblank) begin
          // Leaving blanking: any pending write waits; scanning resumes at once.
          state_d = DISP;
          if (vis) begin
            ram_en_d   = 1'b1;
            ram_addr_d = scan_addr;
          end
        end else if (wr_req) begin
          if (!in_range) begin
            wr_ack_d = 1'b1;
            wr_err_d = 1'b1;
          end else if (budget_q != '0) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            wr_ack_d    = 1'b1;
            budget_d    = budget_q - BW'(1);
          end else begin
            wr_stall_d = 1'b1;
          end
        end
      end
      default: state_d = DISP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= DISP;
      budget_q     <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      wr_stall_q   <= 1'b0;
      wr_err_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      rd_pipe_q    <= 1'b0;
      cell_valid_q <= 1'b0;
      cell_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_ack_q     <= wr_ack_d;
      wr_stall_q   <= wr_stall_d;
      wr_err_q     <= wr_err_d;
      frame_tick_q <= frame_tick_d;
      rd_pipe_q    <= rd_pipe_d;
      cell_valid_q <= cell_valid_d;
      cell_data_q  <= cell_data_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign wr_ack     = wr_ack_q;
  assign wr_stall   = wr_stall_q;
  assign wr_err     = wr_err_q;
  assign frame_tick = frame_tick_q;
  assign cell_valid = cell_valid_q;
  assign cell_data  = cell_data_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a reduced write budget of 4.
module tb_vram_scan_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 4;

  logic              clk;
  logic              rst_n;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_stall;
  logic              wr_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] cell_data;
  logic              cell_valid;
  logic              frame_tick;

  int checks   = 0;
  int failures = 0;

  vram_scan_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WR_BUDGET(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_stall  (wr_stall),
    .wr_err    (wr_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cell_data (cell_data),
    .cell_valid(cell_valid),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pos_x = 10'd0; pos_y = 10'd200;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; ram_rdata = '0;

    // Reset
    step(); step(); step();
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wr_stall", wr_stall, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_cell_valid", cell_valid, 0);
    check("rst_cell_data", cell_data, 0);

    // Scan read: cell (2,1) -> 1*40+2 = 42
    rst_n = 1'b1; pos_x = 10'd35; pos_y = 10'd20; ram_rdata = 4'h5;
    step();
    check("scan_ram_en", ram_en, 1);
    check("scan_ram_we", ram_we, 0);
    check("scan_ram_addr", ram_addr, 42);
    check("scan_no_tick", frame_tick, 0);
    pos_x = 10'd700;
    step();
    check("scan_hblank_en", ram_en, 0);
    check("scan_valid_early", cell_valid, 0);
    step();
    check("scan_cell_valid", cell_valid, 1);
    check("scan_cell_data", cell_data, 5);
    ram_rdata = 4'h9;
    step();
    check("scan_valid_drop", cell_valid, 0);
    check("scan_data_hold", cell_data, 5);

    // Writes never issued in DISP, even in horizontal blank
    pos_y = 10'd479; wr_req = 1'b1; wr_addr = 11'd100; wr_data = 4'd3;
    step();
    check("disp_no_we", ram_we, 0);
    check("disp_no_ack", wr_ack, 0);
    check("disp_479_no_tick", frame_tick, 0);

    // Entry to blanking
    pos_y = 10'd480;
    step();
    check("tick_pulse", frame_tick, 1);
    check("tick_edge_no_ack", wr_ack, 0);
    step();
    check("wr_ack", wr_ack, 1);
    check("wr_we", ram_we, 1);
    check("wr_en", ram_en, 1);
    check("wr_addr", ram_addr, 100);
    check("wr_data", ram_wdata, 3);
    check("tick_single", frame_tick, 0);
    wr_req = 1'b0;
    step();
    check("wr_ack_pulse", wr_ack, 0);
    check("wr_idle_en", ram_en, 0);

    // Bad address
    wr_req = 1'b1; wr_addr = 11'd1200; wr_data = 4'd7;
    step();
    check("bad_ack", wr_ack, 1);
    check("bad_no_en", ram_en, 0);
    check("bad_err", wr_err, 1);
    wr_req = 1'b0;
    step();
    check("bad_ack_pulse", wr_ack, 0);
    check("bad_err_sticky", wr_err, 1);

    // Window close on wrap 1023 -> 0
    pos_y = 10'd1023;
    step();
    check("wrap_no_tick", frame_tick, 0);
    pos_x = 10'd0; pos_y = 10'd0;
    wr_req = 1'b1; wr_addr = 11'd7; wr_data = 4'd2;
    step();
    check("close_no_ack", wr_ack, 0);
    check("close_no_we", ram_we, 0);
    check("close_read_en", ram_en, 1);
    check("close_read_addr", ram_addr, 0);
    pos_x = 10'd700; pos_y = 10'd100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("close_wait_ack", wr_ack, 0);
      check("close_wait_we", ram_we, 0);
    end
    pos_y = 10'd480;
    step();
    check("close_tick", frame_tick, 1);
    check("close_tick_no_ack", wr_ack, 0);
    step();
    check("close_late_ack", wr_ack, 1);
    check("close_late_addr", ram_addr, 7);
    check("close_late_data", ram_wdata, 2);
    check("close_late_we", ram_we, 1);
    wr_req = 1'b0;
    pos_y = 10'd0;
    step();

    // Budget: 6 writes, only 4 granted this blanking
    pos_y = 10'd480;
    step();
    check("bud_tick", frame_tick, 1);
    wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 11'(200 + i); wr_data = 4'(i);
      step();
      check("bud_ack", wr_ack, 1);
      check("bud_addr", ram_addr, 200 + i);
      check("bud_data", ram_wdata, i);
      check("bud_stall_lo", wr_stall, 0);
    end
    wr_addr = 11'd204; wr_data = 4'd4;
    step();
    check("bud_exh_ack", wr_ack, 0);
    check("bud_exh_stall", wr_stall, 1);
    check("bud_exh_en", ram_en, 0);
    step();
    check("bud_exh_stall2", wr_stall, 1);
    check("bud_exh_ack2", wr_ack, 0);
    pos_x = 10'd0; pos_y = 10'd0;
    step();
    check("bud_disp_stall", wr_stall, 1);
    check("bud_disp_ack", wr_ack, 0);
    pos_x = 10'd700; pos_y = 10'd300;
    step();
    pos_y = 10'd480;
    step();
    check("bud_tick2", frame_tick, 1);
    check("bud_stall_clr", wr_stall, 0);
    check("bud_tick2_no_ack", wr_ack, 0);
    step();
    check("bud_rem_ack4", wr_ack, 1);
    check("bud_rem_addr4", ram_addr, 204);
    check("bud_rem_data4", ram_wdata, 4);
    wr_addr = 11'd205; wr_data = 4'd5;
    step();
    check("bud_rem_ack5", wr_ack, 1);
    check("bud_rem_addr5", ram_addr, 205);
    wr_req = 1'b0;
    step();
    check("bud_rem_idle", wr_ack, 0);
    check("err_still_set", wr_err, 1);

    // Reset clears sticky error and outputs
    rst_n = 1'b0;
    step();
    check("rst2_err", wr_err, 0);
    check("rst2_en", ram_en, 0);
    check("rst2_tick", frame_tick, 0);
    rst_n = 1'b1; pos_y = 10'd200;
    step();
    check("rst2_no_tick", frame_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
